// File: rtl/cpu_controller.sv
// Eight-phase fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Drives memory, IR, PC and accumulator strobes from the phase, opcode and alu zero flag.
module cpu_controller (
    input  logic       clk_,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       load_ac,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    phase_e  phase_q;
    phase_e  phase_d;
    opcode_e op;
    logic    aluOp;

    assign op    = opcode_e'(opcode);
    assign aluOp = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    assign phase = phase_q;

    always_ff @(posedge clk_ or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    // HLT parks the sequencer in OP_ADDR; only reset moves it on.
    always_comb begin
        phase_d = phase_e'(phase_q + 3'd1);
        if (phase_q == OP_ADDR && op == OP_HLT) begin
            phase_d = OP_ADDR;
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        inc_pc  = 1'b0;
        halt    = 1'b0;
        unique case (phase_q)
            INST_ADDR: begin
            end
            INST_FETCH: begin
                mem_rd = 1'b1;
            end
            INST_LOAD, IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = (op != OP_HLT);
                halt   = (op == OP_HLT);
            end
            OP_FETCH: begin
                mem_rd = aluOp;
            end
            ALU_OP: begin
                mem_rd  = aluOp;
                load_ac = aluOp;
                inc_pc  = (op == OP_SKZ) && zero;
                load_pc = (op == OP_JMP);
            end
            STORE: begin
                // JMP raises both PC strobes here; the PC lets load_pc win.
                mem_rd  = aluOp;
                load_ac = aluOp;
                inc_pc  = (op == OP_JMP);
                load_pc = (op == OP_JMP);
                mem_wr  = (op == OP_STO);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed table-driven bench for cpu_controller plus hand-written reset and halt sequences.
// Output vectors are packed as {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt}.
module tb_cpu_controller;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    logic       clk_ = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_rd;
    logic       mem_wr;
    logic       load_ir;
    logic       load_ac;
    logic       load_pc;
    logic       inc_pc;
    logic       halt;
    logic [2:0] phase;

    typedef struct {
        logic [2:0] opcode;
        logic       zero;
        logic [2:0] expPhase;
        logic [6:0] expOuts;
    } vector_t;

    vector_t    vectors[$];
    logic [6:0] addOuts[8];
    int         testsRun    = 0;
    int         testsFailed = 0;

    cpu_controller dut (
        .clk_    (clk_),
        .rst_n   (rst_n),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .load_ir (load_ir),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .inc_pc  (inc_pc),
        .halt    (halt),
        .phase   (phase)
    );

    always #5 clk_ = ~clk_;

    function automatic logic [6:0] outsNow();
        return {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt};
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic z);
        opcode = op;
        zero   = z;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] expPhase, input logic [6:0] expOuts);
        testsRun++;
        if (phase !== expPhase || outsNow() !== expOuts) begin
            testsFailed++;
            $display("[TB] FAIL %s: phase=%0d outs=%b, expected phase=%0d outs=%b",
                     name, phase, outsNow(), expPhase, expOuts);
        end
    endtask

    task automatic step();
        @(posedge clk_);
        #1;
    endtask

    // Phases 0-3 are driven with earlyOp so opcode changes there must not matter.
    task automatic addInstr(input logic [2:0] earlyOp, input logic [2:0] op, input logic z,
                            input logic [6:0] o4, input logic [6:0] o5,
                            input logic [6:0] o6, input logic [6:0] o7);
        logic [6:0] exp[8];
        vector_t    v;
        exp[0] = 7'b0000000;
        exp[1] = 7'b1000000;
        exp[2] = 7'b1010000;
        exp[3] = 7'b1010000;
        exp[4] = o4;
        exp[5] = o5;
        exp[6] = o6;
        exp[7] = o7;
        for (int p = 0; p < 8; p++) begin
            v.opcode   = (p < 4) ? earlyOp : op;
            v.zero     = z;
            v.expPhase = 3'(p);
            v.expOuts  = exp[p];
            vectors.push_back(v);
        end
    endtask

    initial begin
        addOuts = '{7'b0000000, 7'b1000000, 7'b1010000, 7'b1010000,
                    7'b0000010, 7'b1000000, 7'b1001000, 7'b1001000};

        addInstr(HLT, ADD, 1'b0, 7'b0000010, 7'b1000000, 7'b1001000, 7'b1001000);
        addInstr(SKZ, SKZ, 1'b1, 7'b0000010, 7'b0000000, 7'b0000010, 7'b0000000);
        addInstr(JMP, SKZ, 1'b0, 7'b0000010, 7'b0000000, 7'b0000000, 7'b0000000);
        addInstr(ADD, JMP, 1'b0, 7'b0000010, 7'b0000000, 7'b0000100, 7'b0000110);
        addInstr(LDA, STO, 1'b1, 7'b0000010, 7'b0000000, 7'b0000000, 7'b0100000);
        addInstr(STO, XOR, 1'b1, 7'b0000010, 7'b1000000, 7'b1001000, 7'b1001000);
        addInstr(HLT, AND, 1'b0, 7'b0000010, 7'b1000000, 7'b1001000, 7'b1001000);
        addInstr(SKZ, LDA, 1'b0, 7'b0000010, 7'b1000000, 7'b1001000, 7'b1001000);

        rst_n = 1'b0;
        applyStimulus(ADD, 1'b0);
        #10;
        checkOutput("resetState", 3'd0, 7'b0000000);
        @(negedge clk_);
        rst_n = 1'b1;

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].opcode, vectors[i].zero);
            checkOutput($sformatf("vec%0d", i), vectors[i].expPhase, vectors[i].expOuts);
            step();
        end

        applyStimulus(ADD, 1'b0);
        for (int i = 0; i < 5; i++) step();
        #2;
        checkOutput("preReset", 3'd5, 7'b1000000);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 3'd0, 7'b0000000);
        @(negedge clk_);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("phaseRun%0d", i), 3'(i), addOuts[i]);
            step();
        end
        checkOutput("phaseWrap", 3'd0, 7'b0000000);

        applyStimulus(HLT, 1'b0);
        for (int i = 0; i < 4; i++) step();
        checkOutput("haltEnter", 3'd4, 7'b0000001);
        for (int i = 0; i < 22; i++) begin
            if (i == 10) applyStimulus(HLT, 1'b1);
            step();
            checkOutput($sformatf("halted%0d", i), 3'd4, 7'b0000001);
        end
        applyStimulus(ADD, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("haltReset", 3'd0, 7'b0000000);
        @(negedge clk_);
        rst_n = 1'b1;
        step();
        checkOutput("afterHalt", 3'd1, 7'b1000000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
